// File: rtl/cpu_pkg.sv
// Shared CPU definitions: shift opcode encodings (match the control unit's Shift
// constants), shift-unit state encoding and opcode classification helpers.
package cpu_pkg;

    typedef enum logic [2:0] {
        OP_SLL  = 3'b000,
        OP_SLLV = 3'b001,
        OP_SRA  = 3'b010,
        OP_SRAV = 3'b011,
        OP_SRL  = 3'b100
    } shift_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } shift_state_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= 3'b100;
    endfunction

    // Variable forms take their amount from rs_val[4:0] instead of shamt.
    function automatic logic op_is_variable(input logic [2:0] op);
        return (op == OP_SLLV) || (op == OP_SRAV);
    endfunction

endpackage

// File: rtl/shift_unit_if.sv
// Start/done handshake and operand/result bundle between the multicycle control
// unit (master) and the iterative shift unit (slave).
interface shift_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       shift_op;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             busy;
    logic             done;
    logic             illegal_op;
    logic [WIDTH-1:0] result;

    modport master (
        output start, shift_op, shamt, rs_val, rt_val,
        input  busy, done, illegal_op, result
    );

    modport slave (
        input  start, shift_op, shamt, rs_val, rt_val,
        output busy, done, illegal_op, result
    );
endinterface

// File: rtl/shift_unit_step.sv
// Combinational single shift step: moves data by 1 or 4 bit positions in the
// direction and fill mode selected by the opcode.
module shift_step
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] data,
    input  logic [2:0]       op,
    input  logic             step4,
    output logic [WIDTH-1:0] data_next
);
    logic [2:0] amt;

    always_comb begin
        amt       = step4 ? 3'd4 : 3'd1;
        data_next = data;
        case (op)
            OP_SLL, OP_SLLV: data_next = data << amt;
            OP_SRA, OP_SRAV: data_next = $signed(data) >>> amt;
            OP_SRL:          data_next = data >> amt;
            default:         data_next = data;
        endcase
    end
endmodule

// File: rtl/shift_unit.sv
// Iterative shift unit: start/done handshake, one shift step per SHIFT cycle.
// SHIFT_UNIT_FAST_EN: steps of 4 bits while at least 4 remain; results unchanged.
module shift_unit
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    shift_unit_if.slave  bus
);
    shift_state_t     state, state_n;
    logic [WIDTH-1:0] data, data_n;
    logic [2:0]       op, op_n;
    logic [4:0]       count, count_n;
    logic             illegal, illegal_n;
    logic [WIDTH-1:0] result, result_n;

    logic             step4;
    logic [4:0]       step_amt;
    logic [WIDTH-1:0] stepped;
    logic [4:0]       accept_count;
    logic             unused_rs_hi;

    assign unused_rs_hi = ^bus.rs_val[WIDTH-1:5];

`ifdef SHIFT_UNIT_FAST_EN
    assign step4 = (count >= 5'd4);
`else
    assign step4 = 1'b0;
`endif
    assign step_amt = step4 ? 5'd4 : 5'd1;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .data      (data),
        .op        (op),
        .step4     (step4),
        .data_next (stepped)
    );

    assign accept_count = op_is_variable(bus.shift_op) ? bus.rs_val[4:0] : bus.shamt;

    always_comb begin
        state_n   = state;
        data_n    = data;
        op_n      = op;
        count_n   = count;
        illegal_n = illegal;
        result_n  = result;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    data_n    = bus.rt_val;
                    op_n      = bus.shift_op;
                    count_n   = accept_count;
                    illegal_n = !op_is_legal(bus.shift_op);
                    // Nothing to shift: present the operand directly in DONE.
                    if (!op_is_legal(bus.shift_op) || accept_count == 5'd0) begin
                        state_n  = ST_DONE;
                        result_n = bus.rt_val;
                    end else begin
                        state_n  = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                data_n  = stepped;
                count_n = count - step_amt;
                if (count == step_amt) begin
                    state_n  = ST_DONE;
                    result_n = stepped;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            data    <= '0;
            op      <= '0;
            count   <= '0;
            illegal <= 1'b0;
            result  <= '0;
        end else begin
            state   <= state_n;
            data    <= data_n;
            op      <= op_n;
            count   <= count_n;
            illegal <= illegal_n;
            result  <= result_n;
        end
    end

    assign bus.busy       = (state == ST_SHIFT);
    assign bus.done       = (state == ST_DONE);
    assign bus.illegal_op = (state == ST_DONE) && illegal;
    assign bus.result     = result;
endmodule
